apple1_bus_ctrl: RTL and testbench

//  Parametrised bus controller between the 6502 core and the Apple-1 memory/peripheral map.

---
 rtl/apple1_bus_pkg.sv | 35 +++
 rtl/apple1_clken_div.sv | 35 +++
 rtl/apple1_bus_ctrl.sv | 137 +++++++++++++
 tb/tb_apple1_bus_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_bus_pkg.sv
// Shared types for the Apple-1 bus controller: FSM states, address regions and
// the default I/O base addresses, plus the region decoder used by the top level.
package apple1_bus_pkg;

    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_RAM_REQ  = 2'd1,
        ST_DSP_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } bus_state_e;

    typedef enum logic [1:0] {
        RGN_RAM = 2'd0,
        RGN_KBD = 2'd1,
        RGN_DSP = 2'd2
    } region_e;

    localparam logic [15:0] KBD_BASE_DEFAULT = 16'hD010;
    localparam logic [15:0] DSP_BASE_DEFAULT = 16'hD012;

    // Each I/O device occupies an aligned pair; bit 0 picks data vs control.
    function automatic region_e decode_region(input logic [15:0] addr,
                                              input logic [15:0] kbd_base,
                                              input logic [15:0] dsp_base);
        region_e rgn;
        rgn = RGN_RAM;
        if (addr[15:1] == kbd_base[15:1]) begin
            rgn = RGN_KBD;
        end else if (addr[15:1] == dsp_base[15:1]) begin
            rgn = RGN_DSP;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/apple1_clken_div.sv
// CPU step divider: counts 0..DIV-1 and wraps, but parks on the terminal count
// while hold is high so a stretched bus cycle releases the CPU immediately.
module apple1_clken_div #(
    parameter int unsigned DIV = 14
) (
    input  logic clk14,
    input  logic rst_n,
    input  logic hold,
    output logic tc
);

    localparam int unsigned   W    = $clog2(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (tc) begin
            cnt_d = hold ? cnt_q : '0;
        end
    end

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apple1_bus_ctrl.sv
// Apple-1 bus controller: paces the 6502 with a clock enable, routes each access to
// RAM, keyboard or display, and stretches the CPU cycle while the target is busy.
module apple1_bus_ctrl
    import apple1_bus_pkg::*;
#(
    parameter int unsigned CLKEN_DIV = 14,
    parameter logic [15:0] KBD_BASE  = KBD_BASE_DEFAULT,
    parameter logic [15:0] DSP_BASE  = DSP_BASE_DEFAULT,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk14,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic [7:0]  cpu_din,
    output logic        cpu_clken,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_rd,
    output logic        ram_wr,
    input  logic        ram_ack,
    input  logic [7:0]  ram_dout,
    output logic        kbd_cs,
    input  logic [7:0]  kbd_dout,
    output logic        dsp_we,
    input  logic        dsp_busy,
    output logic        bus_timeout
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    bus_state_e  state_q;
    logic [15:0] wait_q;
    logic [7:0]  rdata_q;
    logic        wr_q;
    logic [15:0] ram_addr_q;
    logic [7:0]  ram_din_q;

    region_e     region;
    logic        div_tc;
    logic        ram_req;
    logic        dsp_wait;
    logic        wait_expired;

    apple1_clken_div #(
        .DIV (CLKEN_DIV)
    ) u_clken_div (
        .clk14 (clk14),
        .rst_n (rst_n),
        .hold  (state_q != ST_DONE),
        .tc    (div_tc)
    );

    assign region       = decode_region(cpu_addr, KBD_BASE, DSP_BASE);
    assign ram_req      = (state_q == ST_RAM_REQ);
    assign dsp_wait     = (state_q == ST_DSP_WAIT);
    assign wait_expired = (wait_q == TIMEOUT_CNT);

    // Decoded from state so an asynchronous reset withdraws the request at once.
    assign ram_rd      = ram_req & ~wr_q;
    assign ram_wr      = ram_req &  wr_q;
    assign kbd_cs      = rst_n && (state_q == ST_START) && (region == RGN_KBD) && !cpu_we;
    assign dsp_we      = dsp_wait && !dsp_busy;
    assign bus_timeout = wait_expired && ((ram_req && !ram_ack) || (dsp_wait && dsp_busy));
    assign cpu_clken   = (state_q == ST_DONE) && div_tc;
    assign cpu_din     = rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_START;
            wait_q     <= '0;
            rdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_START: begin
                    ram_addr_q <= cpu_addr;
                    ram_din_q  <= cpu_dout;
                    wr_q       <= cpu_we;
                    wait_q     <= '0;
                    case (region)
                        RGN_KBD: begin
                            if (!cpu_we) begin
                                rdata_q <= kbd_dout;
                            end
                            state_q <= ST_DONE;
                        end
                        RGN_DSP: begin
                            if (cpu_we) begin
                                state_q <= cpu_addr[0] ? ST_DONE : ST_DSP_WAIT;
                            end else begin
                                rdata_q <= cpu_addr[0] ? 8'h00 : {dsp_busy, 7'b0};
                                state_q <= ST_DONE;
                            end
                        end
                        default: state_q <= ST_RAM_REQ;
                    endcase
                end
                ST_RAM_REQ: begin
                    // A completion arriving in the expiry cycle still counts.
                    if (ram_ack) begin
                        if (!wr_q) begin
                            rdata_q <= ram_dout;
                        end
                        state_q <= ST_DONE;
                    end else if (wait_expired) begin
                        rdata_q <= 8'hFF;
                        state_q <= ST_DONE;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                ST_DSP_WAIT: begin
                    if (!dsp_busy) begin
                        state_q <= ST_DONE;
                    end else if (wait_expired) begin
                        rdata_q <= 8'hFF;
                        state_q <= ST_DONE;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (div_tc) begin
                        state_q <= ST_START;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apple1_bus_ctrl.sv
// Directed bench for apple1_bus_ctrl with default parameters (CLKEN_DIV=14, TIMEOUT=255).
// Cycle index k counts clock edges since the previous cpu_clken cycle; k=1 is START.
module tb_apple1_bus_ctrl;

    logic        clk14;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  cpu_din;
    logic        cpu_clken;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_rd;
    logic        ram_wr;
    logic        ram_ack;
    logic [7:0]  ram_dout;
    logic        kbd_cs;
    logic [7:0]  kbd_dout;
    logic        dsp_we;
    logic        dsp_busy;
    logic        bus_timeout;

    int n_checks = 0;
    int n_errors = 0;

    apple1_bus_ctrl dut (
        .clk14       (clk14),
        .rst_n       (rst_n),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_we      (cpu_we),
        .cpu_din     (cpu_din),
        .cpu_clken   (cpu_clken),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_rd      (ram_rd),
        .ram_wr      (ram_wr),
        .ram_ack     (ram_ack),
        .ram_dout    (ram_dout),
        .kbd_cs      (kbd_cs),
        .kbd_dout    (kbd_dout),
        .dsp_we      (dsp_we),
        .dsp_busy    (dsp_busy),
        .bus_timeout (bus_timeout)
    );

    initial clk14 = 1'b0;
    always #5 clk14 = ~clk14;

    // Runs one CPU access until cpu_clken (bounded). ack_delay: 0 = ram_ack tied high,
    // N>0 = ack in the (N+1)-th request cycle, <0 = never. dsp_busy is high for k<=busy_cycles.
    task automatic run_access(input logic [15:0] a, input logic [7:0] d, input logic w,
                              input int ack_delay, input int busy_cycles,
                              output int clken_k, output int ack_k, output int dsp_k,
                              output int to_k, output int n_rd, output int n_wr,
                              output int n_kbd, output int n_dsp, output int n_to);
        int req_seen;
        req_seen = 0;
        clken_k = -1; ack_k = -1; dsp_k = -1; to_k = -1;
        n_rd = 0; n_wr = 0; n_kbd = 0; n_dsp = 0; n_to = 0;
        cpu_addr = a;
        cpu_dout = d;
        cpu_we   = w;
        ram_ack  = (ack_delay == 0);
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk14);
            #1;
            dsp_busy = (k <= busy_cycles);
            if (ack_delay == 0) begin
                ram_ack = 1'b1;
            end else if (ram_rd || ram_wr) begin
                ram_ack = (ack_delay > 0) && (req_seen == ack_delay);
                req_seen++;
            end else begin
                ram_ack = 1'b0;
            end
            #1;
            if (ram_rd) n_rd++;
            if (ram_wr) n_wr++;
            if (kbd_cs) n_kbd++;
            if (dsp_we) begin
                n_dsp++;
                if (dsp_k < 0) dsp_k = k;
            end
            if (bus_timeout) begin
                n_to++;
                if (to_k < 0) to_k = k;
            end
            if (ram_ack && (ram_rd || ram_wr) && ack_k < 0) ack_k = k;
            if (cpu_clken) begin
                clken_k = k;
                break;
            end
        end
        $display("access addr=%h we=%0b wdata=%h -> cpu_din=%h clken_k=%0d rd=%0d wr=%0d kbd=%0d dsp=%0d to=%0d",
                 a, w, d, cpu_din, clken_k, n_rd, n_wr, n_kbd, n_dsp, n_to);
    endtask

    int ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto;

    task automatic test_reset();
        rst_n = 1'b0; cpu_addr = 16'h0280; cpu_dout = 8'h00; cpu_we = 1'b0;
        ram_ack = 1'b0; ram_dout = 8'h11; kbd_dout = 8'h00; dsp_busy = 1'b0;
        repeat (3) @(posedge clk14);
        #1;
        n_checks++;
        if ({cpu_din, ram_addr, ram_din, ram_rd, ram_wr, cpu_clken, kbd_cs, dsp_we, bus_timeout} !== 46'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got din=%h addr=%h wdata=%h rd=%b wr=%b clken=%b expected all zero",
                     cpu_din, ram_addr, ram_din, ram_rd, ram_wr, cpu_clken);
        end
        @(negedge clk14);
        rst_n = 1'b1;
        // The release cycle is START (k=0), so cpu_clken falls 13 edges later: the 14th cycle.
        run_access(16'h0280, 8'h00, 1'b0, 0, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (ck !== 13) begin n_errors++; $display("FAIL reset_first_clken: got %0d expected 13", ck); end
        n_checks++;
        if (cpu_din !== 8'h11) begin n_errors++; $display("FAIL reset_first_read: got %h expected 11", cpu_din); end
    endtask

    task automatic test_reset_mid_access();
        ram_ack = 1'b0; cpu_addr = 16'h0280; cpu_we = 1'b0;
        @(posedge clk14); #1;
        @(posedge clk14); #1;
        n_checks++;
        if (ram_rd !== 1'b1) begin n_errors++; $display("FAIL mid_reset_req_before: got %b expected 1", ram_rd); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ram_rd !== 1'b0) begin n_errors++; $display("FAIL mid_reset_req_drop: got %b expected 0", ram_rd); end
        n_checks++;
        if (cpu_din !== 8'h00) begin n_errors++; $display("FAIL mid_reset_din: got %h expected 00", cpu_din); end
        repeat (2) @(posedge clk14);
        @(negedge clk14);
        rst_n = 1'b1;
        run_access(16'h0280, 8'h00, 1'b0, 0, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (ck !== 13) begin n_errors++; $display("FAIL mid_reset_first_clken: got %0d expected 13", ck); end
    endtask

    task automatic test_ram_read();
        ram_dout = 8'hA5;
        run_access(16'h0280, 8'h00, 1'b0, 0, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (ck !== 14) begin n_errors++; $display("FAIL ram_read_period: got %0d expected 14", ck); end
        n_checks++;
        if (nrd !== 1) begin n_errors++; $display("FAIL ram_read_rd_cycles: got %0d expected 1", nrd); end
        n_checks++;
        if (cpu_din !== 8'hA5) begin n_errors++; $display("FAIL ram_read_din: got %h expected a5", cpu_din); end
        n_checks++;
        if (ram_addr !== 16'h0280) begin n_errors++; $display("FAIL ram_read_addr: got %h expected 0280", ram_addr); end
    endtask

    task automatic test_late_ack();
        ram_dout = 8'h3C;
        // Request starts at k=2; ack 20 cycles later at k=22, so cpu_clken at k=23.
        run_access(16'h1234, 8'h00, 1'b0, 20, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (ak !== 22) begin n_errors++; $display("FAIL late_ack_cycle: got %0d expected 22", ak); end
        n_checks++;
        if (ck !== 23) begin n_errors++; $display("FAIL late_ack_clken: got %0d expected 23", ck); end
        n_checks++;
        if (cpu_din !== 8'h3C) begin n_errors++; $display("FAIL late_ack_din: got %h expected 3c", cpu_din); end
    endtask

    task automatic test_ram_write();
        run_access(16'h0300, 8'h5A, 1'b1, 0, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (nwr !== 1) begin n_errors++; $display("FAIL ram_write_wr_cycles: got %0d expected 1", nwr); end
        n_checks++;
        if (nrd !== 0) begin n_errors++; $display("FAIL ram_write_rd_cycles: got %0d expected 0", nrd); end
        n_checks++;
        if (ram_din !== 8'h5A) begin n_errors++; $display("FAIL ram_write_data: got %h expected 5a", ram_din); end
        n_checks++;
        if (cpu_din !== 8'h3C) begin n_errors++; $display("FAIL ram_write_din_kept: got %h expected 3c", cpu_din); end
        n_checks++;
        if (ck !== 14) begin n_errors++; $display("FAIL ram_write_period: got %0d expected 14", ck); end
    endtask

    task automatic test_dsp_write();
        // Busy for k=1..5; first DSP_WAIT cycle with busy low is k=6.
        run_access(16'hD012, 8'hC1, 1'b1, 0, 5, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (dk !== 6) begin n_errors++; $display("FAIL dsp_write_we_cycle: got %0d expected 6", dk); end
        n_checks++;
        if (ndsp !== 1) begin n_errors++; $display("FAIL dsp_write_we_count: got %0d expected 1", ndsp); end
        n_checks++;
        if (ram_din !== 8'hC1) begin n_errors++; $display("FAIL dsp_write_data: got %h expected c1", ram_din); end
        n_checks++;
        if (nrd + nwr !== 0) begin n_errors++; $display("FAIL dsp_write_no_ram: got %0d expected 0", nrd + nwr); end
        n_checks++;
        if (ck !== 14) begin n_errors++; $display("FAIL dsp_write_period: got %0d expected 14", ck); end
    endtask

    task automatic test_dsp_status();
        run_access(16'hD012, 8'h00, 1'b0, 0, 100, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (cpu_din !== 8'h80) begin n_errors++; $display("FAIL dsp_status_busy: got %h expected 80", cpu_din); end
        run_access(16'hD012, 8'h00, 1'b0, 0, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (cpu_din !== 8'h00) begin n_errors++; $display("FAIL dsp_status_idle: got %h expected 00", cpu_din); end
    endtask

    task automatic test_kbd();
        kbd_dout = 8'h8D;
        run_access(16'hD010, 8'h00, 1'b0, 0, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (nkbd !== 1) begin n_errors++; $display("FAIL kbd_cs_pulses: got %0d expected 1", nkbd); end
        n_checks++;
        if (cpu_din !== 8'h8D) begin n_errors++; $display("FAIL kbd_din: got %h expected 8d", cpu_din); end
        n_checks++;
        if (nrd !== 0) begin n_errors++; $display("FAIL kbd_no_ram: got %0d expected 0", nrd); end
    endtask

    task automatic test_timeout();
        ram_dout = 8'h42;
        // Wait counter is 0 at k=2 and reaches 255 at k=257, after 255 waited cycles.
        run_access(16'h0400, 8'h00, 1'b0, -1, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (tk !== 257) begin n_errors++; $display("FAIL timeout_cycle: got %0d expected 257", tk); end
        n_checks++;
        if (nto !== 1) begin n_errors++; $display("FAIL timeout_pulses: got %0d expected 1", nto); end
        n_checks++;
        if (ck !== 258) begin n_errors++; $display("FAIL timeout_clken: got %0d expected 258", ck); end
        n_checks++;
        if (cpu_din !== 8'hFF) begin n_errors++; $display("FAIL timeout_din: got %h expected ff", cpu_din); end
    endtask

    task automatic test_back_to_back();
        ram_dout = 8'h77;
        run_access(16'h0281, 8'h00, 1'b0, 0, 0, ck, ak, dk, tk, nrd, nwr, nkbd, ndsp, nto);
        n_checks++;
        if (ck !== 14) begin n_errors++; $display("FAIL b2b_period: got %0d expected 14", ck); end
        n_checks++;
        if (cpu_din !== 8'h77) begin n_errors++; $display("FAIL b2b_din: got %h expected 77", cpu_din); end
        n_checks++;
        if (nto !== 0) begin n_errors++; $display("FAIL b2b_no_timeout: got %0d expected 0", nto); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_ram_read();
        test_late_ack();
        test_ram_write();
        test_dsp_write();
        test_dsp_status();
        test_kbd();
        test_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
